clk_div_bank: RTL
=================

Name: clk_div_bank

Overview:
- Synthesizable, parametrised multi-channel clock divider.
- Derives NUM_CH divided clock-like outputs from one fast master clock, e.g. 100/50/25 MHz from 200 MHz.
- Each channel has a programmable divide ratio, its own enable, glitch-free ratio changes and a one-cycle tick strobe.
- A global sync input phase-aligns all channels. Sits at the top of test and DUT harnesses, replacing free-running behavioural clock loops.

Parameters:
- NUM_CH, 3, number of independent divider channels.
- DIV_W, 8, width of each divide-ratio field; maximum ratio 2^DIV_W-1.
- MIN_DIV, 2, smallest legal ratio; lower programmed values are clamped up to this.

Ports:
- clk  input  1  master clock; all logic on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- en  input  NUM_CH  per-channel run enable.
- div  input  NUM_CH*DIV_W  per-channel divide ratio; channel i occupies bits [i*DIV_W +: DIV_W].
- sync  input  1  single-cycle restart of all enabled channels at phase 0.
- clk_out  output  NUM_CH  registered divided outputs.
- tick  output  NUM_CH  one-cycle pulse, coincident with each clk_out rising edge.
- running  output  NUM_CH  channel is in RUN state.

Behaviour:
- Reset: rst_n=0 sampled at a clk edge puts every channel in IDLE. Next-cycle values: clk_out=0, tick=0, running=0, cnt=0, div_act=MIN_DIV. Reset overrides all inputs, including mid-period.
- Per-channel state: IDLE, RUN. Per-channel registers:
  - cnt, DIV_W bits.
  - div_act, the latched ratio, DIV_W bits.
  - hi_len = ceil(div_act/2), DIV_W bits, precomputed at latch time.
- Clamp rule: eff(d) = MIN_DIV if d < MIN_DIV, else d.
- Latch rule: div_act and hi_len are loaded only at a period start, so an output period is never truncated or stretched.
- IDLE, en=1: next cycle RUN with cnt=0, clk_out=1, tick=1, div_act=eff(div). Latency is one clk from en sampled high to the first clk_out rise.
- IDLE, en=0: stays IDLE with all outputs 0.
- RUN, cnt != div_act-1: cnt=cnt+1, clk_out=(cnt+1 < hi_len), tick=0.
- RUN, cnt == div_act-1 (period end):
  - en=1: cnt=0, clk_out=1, tick=1, reload div_act and hi_len from the current div.
  - en=0: go to IDLE with clk_out=0, tick=0. Graceful stop: en may drop at any time, but the output always completes its current period.
- Period and duty: period = div_act clk cycles. High phase = ceil(div_act/2); low phase = floor(div_act/2).
  - Even ratios give 50% duty.
  - Odd ratios give one extra high cycle, e.g. ratio 3 is high 2, low 1.
- sync=1 has priority over normal sequencing, excluding reset:
  - Channels with en=1 enter RUN next cycle with cnt=0, clk_out=1, tick=1, reloading div.
  - Channels with en=0 are forced to IDLE immediately; this is the only abrupt stop.
  - All enabled channels are therefore phase-aligned.
- running mirrors the state register (1 in RUN).
- Simultaneous events:
  - div changing mid-period is ignored until the period end.
  - en 0→1 on the same cycle the channel returns to IDLE does not restart until the following cycle, since the channel was still in RUN at that sample.
  - Max ratio 2^DIV_W-1: cnt never wraps past div_act-1.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package clk_div_pkg:
  - typedef enum logic {IDLE, RUN} ch_state_t.
  - function eff_div(d, MIN_DIV).
  - function half_up(d) returning ceil(d/2).
- Sub-module clk_div_channel: one channel's FSM, counter and output registers. Parameters DIV_W and MIN_DIV; scalar en, div and shared sync.
- clk_div_bank is a generate loop of NUM_CH instances plus div-bus slicing.

Test Plan:
- Reset, then en=3'b111 with div={8,4,2}: first clk_out rise on all channels one cycle after en. Periods are 2/4/8 clk, 50% duty, one tick per period, running=111.
- div=3 on ch0: clk_out pattern 1,1,0 repeating; tick every 3 cycles. div=0 and div=1 both behave as div=2.
- Change ch1 div 4→6 at cnt=1: current period finishes 4 cycles (high 2, low 2), next period is 6 cycles (high 3, low 3), no short pulse.
- Drop ch2 en at cnt=2 of div=8: ch2 completes all 8 cycles, then clk_out=0 and running=0. sync pulse with en=011: ch0/ch1 tick on the same cycle, ch2 stays IDLE.
- Assert rst_n=0 mid-period on all running channels: next cycle clk_out=0, tick=0, running=0. On release with en held, first tick arrives one cycle after the rst_n=1 sample.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and ratio helpers for the clock divider bank.
// The helpers work on 32-bit values so they can be used with any DIV_W.
package clk_div_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } ch_state_t;

   // Ratios below the legal minimum are raised to that minimum.
   function automatic int unsigned eff_div(input int unsigned d, input int unsigned min_div);
      return (d < min_div) ? min_div : d;
   endfunction

   // High-phase length: odd ratios spend the extra cycle high.
   function automatic int unsigned half_up(input int unsigned d);
      return (d + 32'd1) / 32'd2;
   endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: IDLE/RUN state, period counter, and registered clk_out/tick.
// The ratio is only latched when a period starts, so periods are never cut short or stretched.
module clk_div_channel
   import clk_div_pkg::*;
#(
   parameter int unsigned DIV_W   = 8,
   parameter int unsigned MIN_DIV = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   input  logic             sync,
   output logic             clk_out,
   output logic             tick,
   output logic             running
);

   localparam logic [DIV_W-1:0] ONE        = DIV_W'(1);
   localparam logic [DIV_W-1:0] RST_DIV    = DIV_W'(MIN_DIV);
   localparam logic [DIV_W-1:0] RST_HI_LEN = DIV_W'(half_up(MIN_DIV));

   ch_state_t        state, state_n;
   logic [DIV_W-1:0] cnt, cnt_n;
   logic [DIV_W-1:0] div_act, div_act_n;
   logic [DIV_W-1:0] hi_len, hi_len_n;
   logic             clk_out_n, tick_n;
   logic             start;
   logic [DIV_W-1:0] div_eff, div_half, cnt_inc;

   assign div_eff  = DIV_W'(eff_div(32'(div), MIN_DIV));
   assign div_half = DIV_W'(half_up(32'(div_eff)));
   assign cnt_inc  = cnt + ONE;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         div_act <= RST_DIV;
         hi_len  <= RST_HI_LEN;
         clk_out <= 1'b0;
         tick    <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         div_act <= div_act_n;
         hi_len  <= hi_len_n;
         clk_out <= clk_out_n;
         tick    <= tick_n;
      end
   end

   // sync outranks normal sequencing; it is also the only way to stop a channel mid-period.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      div_act_n = div_act;
      hi_len_n  = hi_len;
      clk_out_n = 1'b0;
      tick_n    = 1'b0;
      start     = 1'b0;

      if (sync) begin
         if (en) begin
            start = 1'b1;
         end else begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (en) start = 1'b1;
            end
            RUN: begin
               if (cnt != div_act - ONE) begin
                  cnt_n     = cnt_inc;
                  clk_out_n = (cnt_inc < hi_len);
               end else if (en) begin
                  start = 1'b1;
               end else begin
                  state_n = IDLE;
                  cnt_n   = '0;
               end
            end
            default: begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         endcase
      end

      if (start) begin
         state_n   = RUN;
         cnt_n     = '0;
         div_act_n = div_eff;
         hi_len_n  = div_half;
         clk_out_n = 1'b1;
         tick_n    = 1'b1;
      end
   end

   assign running = (state == RUN);

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent clock-divider channels sharing one master clock and sync.
// Each channel takes its own DIV_W-bit slice of the packed ratio bus.
module clk_div_bank
   import clk_div_pkg::*;
#(
   parameter int unsigned NUM_CH  = 3,
   parameter int unsigned DIV_W   = 8,
   parameter int unsigned MIN_DIV = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH-1:0]       en,
   input  logic [NUM_CH*DIV_W-1:0] div,
   input  logic                    sync,
   output logic [NUM_CH-1:0]       clk_out,
   output logic [NUM_CH-1:0]       tick,
   output logic [NUM_CH-1:0]       running
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clk_div_channel #(
         .DIV_W   (DIV_W),
         .MIN_DIV (MIN_DIV)
      ) u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .en      (en[i]),
         .div     (div[i*DIV_W +: DIV_W]),
         .sync    (sync),
         .clk_out (clk_out[i]),
         .tick    (tick[i]),
         .running (running[i])
      );
   end

endmodule
